pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch PC register and decides the next PC each cycle from three sources: sequential (PC+4), a redirect from the branch/jump resolution logic, or a hold caused by a stall.
- Sits between the branch/jump next-PC logic in decode and instruction memory / the F/D pipeline register.
- Latches redirects that arrive during a stall, optionally squashes the wrong-path fetch, traps misaligned targets and counts applied redirects.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = MIPS branch-delay-slot semantics (no squash); 0 = squash the instruction fetched after a taken redirect.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- stall  input  1  hazard unit hold; PC must not advance while 1.
- jump_valid  input  1  one-cycle pulse: the jump_flag/jump_target pair is valid this cycle.
- jump_flag  input  1  taken/untaken decision for the control-transfer instruction in decode.
- jump_target  input  32  redirect target (branch, jal or jr address).
- pc  output  32  current fetch address.
- flush_d  output  1  combinational; F/D register loads a bubble on this edge.
- misaligned  output  1  sticky fault flag: a target with [1:0] != 0 was presented.
- pending  output  1  a redirect is latched and waiting for stall to drop.
- redirect_cnt  output  16  count of applied redirects, saturating.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC; state=RUN; pending=0; misaligned=0; redirect_cnt=0; internal pend_target=0. flush_d=0 while in reset.
- Request qualifier: req = jump_valid & jump_flag. jump_flag or jump_target without jump_valid is ignored. jump_valid with jump_flag=0 is a no-op, so PC continues sequentially.
- State RUN:
  - req & target[1:0]!=0 -> FAULT: misaligned<=1, pc holds. This applies regardless of stall.
  - req & !stall -> pc<=jump_target; redirect_cnt++. flush_d=1 this cycle if DELAY_SLOT=0.
  - req & stall -> PEND: pend_target<=jump_target, pending<=1, pc holds.
  - !req & !stall -> pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - !req & stall -> pc holds.
- State PEND:
  - stall=1 -> hold. Any new req is dropped; the first request wins.
  - stall=0 -> pc<=pend_target; pending<=0; redirect_cnt++; return to RUN. flush_d=1 this cycle if DELAY_SLOT=0. A req in the same cycle is dropped.
- State FAULT:
  - pc frozen, misaligned=1, flush_d=1 every cycle. stall and req are ignored.
  - Only reset exits this state.
- Latency: an unstalled redirect takes effect on the next clock edge. A stalled redirect takes effect on the first edge with stall=0.
- redirect_cnt saturates at 16'hFFFF, with no wrap.
- Reset asserted mid-PEND discards pend_target. No redirect is applied after reset is released.
- flush_d is a pure function of state, req, stall and the DELAY_SLOT parameter, with no extra registered delay. It is 0 whenever no redirect fires (except in FAULT).
- Target arithmetic is 32-bit unsigned. The sequencer never alters jump_target; it only checks alignment.

Test Plan:
- Reset then 3 unstalled cycles with no req -> pc = 0x3000, 0x3004, 0x3008, 0x300C; redirect_cnt=0.
- At pc=0x3008, req with target 0x3100, stall=0 -> next pc=0x3100; redirect_cnt=1. flush_d=1 on that edge only with DELAY_SLOT=0, and 0 with DELAY_SLOT=1.
- req with target 0x3200 while stall=1 for 3 cycles, plus a second req (0x3300) during the stall -> pending=1 and pc held; when stall drops, pc=0x3200 and pending=0; 0x3300 is never loaded.
- req with target 0x3102 -> misaligned=1 and pc frozen; further reqs and stall toggling have no effect until reset, after which pc=0x3000 and misaligned=0.
- Preload redirect_cnt to 0xFFFE via 0xFFFE redirects, then 2 more -> redirect_cnt reads 0xFFFF and stays there.
- Assert reset while in PEND (target 0x4000), then release -> pc=0x3000, pending=0, and the next cycles are sequential from 0x3000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: redirect/stall requests in, fetch PC and status out.
interface pc_sequencer_if;
    logic        stall;
    logic        jump_valid;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        flush_d;
    logic        misaligned;
    logic        pending;
    logic [15:0] redirect_cnt;

    // Decode / hazard side: drives requests, observes PC and status.
    modport master (
        output stall, jump_valid, jump_flag, jump_target,
        input  pc, flush_d, misaligned, pending, redirect_cnt
    );

    // Sequencer side.
    modport slave (
        input  stall, jump_valid, jump_flag, jump_target,
        output pc, flush_d, misaligned, pending, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: picks PC+4, a redirect target, or hold each cycle.
// Redirects arriving under stall are parked until the stall drops; a
// misaligned target freezes the sequencer until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic           clk,
    input  logic           reset,   // asynchronous, active low
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PEND  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic NO_DS = (DELAY_SLOT == 0);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_target_q;
    logic        pending_q;
    logic        misaligned_q;
    logic [15:0] cnt_q;

    logic req;
    logic tgt_misal;
    logic flush_d;

    assign req       = bus.jump_valid & bus.jump_flag;
    assign tgt_misal = |bus.jump_target[1:0];

    // Bubble into F/D on the same edge a redirect is applied (no delay slot),
    // and continuously once faulted. Never asserted while in reset.
    always_comb begin
        flush_d = 1'b0;
        if (reset) begin
            case (state_q)
                S_RUN:   flush_d = NO_DS & req & ~tgt_misal & ~bus.stall;
                S_PEND:  flush_d = NO_DS & ~bus.stall;
                S_FAULT: flush_d = 1'b1;
                default: flush_d = 1'b0;
            endcase
        end
    end

    // Sequencer FSM: PC, parked redirect, fault flag and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0;
            pending_q     <= 1'b0;
            misaligned_q  <= 1'b0;
            cnt_q         <= 16'h0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (req && tgt_misal) begin
                        // Alignment is checked before stall: fault wins.
                        state_q      <= S_FAULT;
                        misaligned_q <= 1'b1;
                    end else if (req && !bus.stall) begin
                        pc_q <= bus.jump_target;
                        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                    end else if (req) begin
                        state_q       <= S_PEND;
                        pend_target_q <= bus.jump_target;
                        pending_q     <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_PEND: begin
                    // First redirect wins; anything arriving now is dropped.
                    if (!bus.stall) begin
                        state_q   <= S_RUN;
                        pc_q      <= pend_target_q;
                        pending_q <= 1'b0;
                        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_FAULT: begin
                    // Frozen until reset.
                    misaligned_q <= 1'b1;
                end
                default: begin
                    state_q <= S_FAULT;
                    misaligned_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.flush_d      = flush_d;
    assign bus.misaligned   = misaligned_q;
    assign bus.pending      = pending_q;
    assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one instance with delay-slot semantics,
// one without, driven by identical directed vectors.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
        logic [15:0] cnt;
        logic        fl1;   // flush_d expected with DELAY_SLOT=1
        logic        fl0;   // flush_d expected with DELAY_SLOT=0
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    pc_sequencer_if bus1 ();
    pc_sequencer_if bus0 ();

    pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1)
    );
    pc_sequencer #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("pc_ds1",   bus1.pc,                   e.pc);
            chk("pc_ds0",   bus0.pc,                   e.pc);
            chk("pend_ds1", {31'b0, bus1.pending},     {31'b0, e.pend});
            chk("pend_ds0", {31'b0, bus0.pending},     {31'b0, e.pend});
            chk("mis_ds1",  {31'b0, bus1.misaligned},  {31'b0, e.mis});
            chk("mis_ds0",  {31'b0, bus0.misaligned},  {31'b0, e.mis});
            chk("cnt_ds1",  {16'b0, bus1.redirect_cnt}, {16'b0, e.cnt});
            chk("cnt_ds0",  {16'b0, bus0.redirect_cnt}, {16'b0, e.cnt});
            chk("flush_ds1", {31'b0, bus1.flush_d},    {31'b0, e.fl1});
            chk("flush_ds0", {31'b0, bus0.flush_d},    {31'b0, e.fl0});
        end
    end

    // Apply inputs just after a rising edge and queue what should be seen
    // before the next one.
    task automatic step(input logic r, input logic s, input logic jv, input logic jf,
                        input logic [31:0] t, input logic [31:0] epc, input logic ep,
                        input logic em, input logic [15:0] ec, input logic ef1,
                        input logic ef0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus1.stall = s; bus1.jump_valid = jv; bus1.jump_flag = jf; bus1.jump_target = t;
        bus0.stall = s; bus0.jump_valid = jv; bus0.jump_flag = jf; bus0.jump_target = t;
        e.pc = epc; e.pend = ep; e.mis = em; e.cnt = ec; e.fl1 = ef1; e.fl0 = ef0;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] tgt(input int i);
        logic [31:0] k;
        k = i;
        return 32'h0001_0000 + {k[29:0] & 30'hFF, 2'b00};
    endfunction

    initial begin
        bus1.stall = 0; bus1.jump_valid = 0; bus1.jump_flag = 0; bus1.jump_target = 0;
        bus0.stall = 0; bus0.jump_valid = 0; bus0.jump_flag = 0; bus0.jump_target = 0;
        //   rst s jv jf target          pc            pnd mis cnt     f1 f0
        step(0, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0); // reset state
        step(0, 0, 1, 1, 32'h100,       32'h3000,     0, 0, 16'd0, 0, 0); // no flush in reset
        step(1, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h3004,     0, 0, 16'd0, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h3008,     0, 0, 16'd0, 0, 0);
        step(1, 0, 1, 0, 32'h5000,      32'h300C,     0, 0, 16'd0, 0, 0); // not taken
        step(1, 0, 0, 1, 32'h5000,      32'h3010,     0, 0, 16'd0, 0, 0); // no valid
        step(1, 0, 1, 1, 32'h3100,      32'h3014,     0, 0, 16'd0, 0, 1); // redirect
        step(1, 0, 0, 0, 32'h0,         32'h3100,     0, 0, 16'd1, 0, 0);
        step(1, 1, 1, 1, 32'h3200,      32'h3104,     0, 0, 16'd1, 0, 0); // stalled req
        step(1, 1, 1, 1, 32'h3300,      32'h3104,     1, 0, 16'd1, 0, 0); // dropped
        step(1, 1, 0, 0, 32'h0,         32'h3104,     1, 0, 16'd1, 0, 0);
        step(1, 0, 1, 1, 32'h3300,      32'h3104,     1, 0, 16'd1, 0, 1); // release
        step(1, 0, 0, 0, 32'h0,         32'h3200,     0, 0, 16'd2, 0, 0);
        step(1, 1, 0, 0, 32'h0,         32'h3204,     0, 0, 16'd2, 0, 0); // plain stall
        step(1, 0, 0, 0, 32'h0,         32'h3204,     0, 0, 16'd2, 0, 0);
        step(1, 1, 1, 1, 32'h3102,      32'h3208,     0, 0, 16'd2, 0, 0); // misaligned
        step(1, 0, 1, 1, 32'h3400,      32'h3208,     0, 1, 16'd2, 1, 1); // FAULT
        step(1, 1, 0, 0, 32'h0,         32'h3208,     0, 1, 16'd2, 1, 1);
        step(1, 0, 1, 1, 32'h3400,      32'h3208,     0, 1, 16'd2, 1, 1);
        step(0, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0); // reset exits
        step(1, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h3004,     0, 0, 16'd0, 0, 0);
        step(1, 1, 1, 1, 32'h4000,      32'h3008,     0, 0, 16'd0, 0, 0); // park 0x4000
        step(1, 1, 0, 0, 32'h0,         32'h3008,     1, 0, 16'd0, 0, 0);
        step(0, 1, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0); // reset in PEND
        step(1, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 16'd0, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h3004,     0, 0, 16'd0, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h3008,     0, 0, 16'd0, 0, 0);
        step(1, 0, 1, 1, 32'hFFFF_FFFC, 32'h300C,     0, 0, 16'd0, 0, 1);
        step(1, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 16'd1, 0, 0);
        step(1, 0, 0, 0, 32'h0,         32'h0,        0, 0, 16'd1, 0, 0); // wrap
        step(1, 0, 0, 0, 32'h0,         32'h4,        0, 0, 16'd1, 0, 0);

        // Back-to-back redirects driving the counter into saturation.
        for (int i = 0; i < 65536; i++) begin
            int          c;
            logic [15:0] ec;
            c  = 1 + i;
            ec = (c > 65535) ? 16'hFFFF : c[15:0];
            step(1, 0, 1, 1, tgt(i), (i == 0) ? 32'h8 : tgt(i - 1), 0, 0, ec, 0, 1);
        end
        step(1, 0, 0, 0, 32'h0, tgt(65535),          0, 0, 16'hFFFF, 0, 0);
        step(1, 0, 0, 0, 32'h0, tgt(65535) + 32'd4,  0, 0, 16'hFFFF, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d records left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
